// File: rtl/conv_frame_ctrl.sv
`timescale 1ns/1ps
// conv_frame_ctrl
// Frame sequencer for an external 3x3 convolution engine. It holds the nine
// kernel weights, gates the raster pixel stream into the engine, tracks
// results still inside the engine pipeline, and drops border results. Valid
// results go into a small output FIFO that is presented as a stream, and
// m_last marks the final result of the frame.
module conv_frame_ctrl #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIPE_LAT   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic [71:0] flat_weights,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        eng_in_valid,
  output logic [7:0]  eng_in_data,
  input  logic        eng_out_valid,
  input  logic [31:0] eng_out_pixel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NW    = AW + 1;

  // Elaboration-time sanity checks on the geometry.
  if (PIPE_LAT < 1) begin : g_bad_pipe_lat
    $error("conv_frame_ctrl: PIPE_LAT must be at least 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("conv_frame_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((IMG_WIDTH < 3) || (IMG_HEIGHT < 3)) begin : g_bad_image
    $error("conv_frame_ctrl: image must be at least 3x3");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  issued_reg;
  logic [CW-1:0]  out_col_reg;
  logic [RW-1:0]  out_row_reg;
  logic [NW-1:0]  inflight_reg;
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [NW-1:0]  fifo_count_reg;
  logic [32:0]    fifo_mem [0:FIFO_DEPTH-1];

  logic transfer, out_run, push, pop, inflight_dec, fifo_clear, is_last;

  // Kernel weights, one register per tap; writable only while idle.
  for (genvar gi = 0; gi < 9; gi++) begin : g_weight
    logic [7:0] weight_reg;
    // Weight tap gi: loads on a matching cfg write in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        weight_reg <= '0;
      else if (cfg_we && (state_reg == IDLE) && (cfg_addr == 4'(gi)))
        weight_reg <= cfg_wdata;
    end
    assign flat_weights[8*gi +: 8] = weight_reg;
  end

  // Input side: room is reserved for every result still in the engine so
  // the FIFO can never overflow even with m_ready held low.
  assign s_ready = (state_reg == RUN) && (issued_reg < IW'(TOTAL)) &&
                   (({1'b0, fifo_count_reg} + {1'b0, inflight_reg}) < (NW+1)'(FIFO_DEPTH));
  assign transfer     = s_valid && s_ready;
  assign eng_in_valid = transfer;
  assign eng_in_data  = s_data;

  // Output side: results only count toward the frame while running; in IDLE
  // (e.g. after a reset) and FLUSH they are dropped.
  assign out_run      = eng_out_valid && (state_reg == RUN);
  assign inflight_dec = eng_out_valid && (inflight_reg != '0);
  assign is_last      = (out_row_reg == RW'(IMG_HEIGHT - 1)) && (out_col_reg == CW'(IMG_WIDTH - 1));
  assign push         = out_run && (out_row_reg >= RW'(2)) && (out_col_reg >= CW'(2));
  assign fifo_clear   = (state_reg == RUN) && abort;
  assign m_valid      = (fifo_count_reg != '0);
  assign pop          = m_valid && m_ready;
  assign m_data       = m_valid ? fifo_mem[rd_ptr_reg][31:0] : 32'd0;
  assign m_last       = m_valid && fifo_mem[rd_ptr_reg][32];

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and status decode; abort has priority over completion.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (abort)
          state_next = FLUSH;
        else if ((issued_reg == IW'(TOTAL)) && (inflight_reg == '0) && (fifo_count_reg == '0))
          state_next = DONE;
      end
      FLUSH: begin
        busy = 1'b1;
        if (inflight_reg == '0) state_next = IDLE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Issued-pixel count and output raster position of the next engine result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_reg  <= '0;
      out_col_reg <= '0;
      out_row_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      issued_reg  <= '0;
      out_col_reg <= '0;
      out_row_reg <= '0;
    end else begin
      if (transfer) issued_reg <= issued_reg + IW'(1);
      if (out_run) begin
        if (out_col_reg == CW'(IMG_WIDTH - 1)) begin
          out_col_reg <= '0;
          out_row_reg <= out_row_reg + RW'(1);
        end else begin
          out_col_reg <= out_col_reg + CW'(1);
        end
      end
    end
  end

  // Results issued to the engine but not yet returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else begin
      case ({transfer, inflight_dec})
        2'b10:   inflight_reg <= inflight_reg + NW'(1);
        2'b01:   inflight_reg <= inflight_reg - NW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // FIFO pointers and occupancy; abort empties it outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else if (fifo_clear) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + NW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - NW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // FIFO storage: {last, pixel}; contents need no reset, occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {is_last, eng_out_pixel};
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for conv_frame_ctrl on a 4x4 image with a behavioural 3x3 engine.
// Expected results are pushed to a queue at frame start; a monitor pops and
// compares whenever the DUT hands over a result.
module tb_conv_frame_ctrl;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int LAT = 8;
  localparam int FD  = 16;
  localparam int HN  = 2 * W + 2;
  localparam logic [71:0] W_ONES = {9{8'h01}};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [71:0] flat_weights;
  logic        start, abort, busy, done;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        eng_in_valid;
  logic [7:0]  eng_in_data;
  logic        eng_out_valid;
  logic [31:0] eng_out_pixel;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [32:0] exp_q [$];
  logic [7:0]  ones [16];
  logic [7:0]  ramp [16];

  always #5 clk = ~clk;

  conv_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .flat_weights(flat_weights),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_pixel(eng_out_pixel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // Engine model: window sum over the last 2W+3 streamed pixels, fixed latency,
  // never reset (stale history only touches discarded border results).
  logic [HN*8-1:0]   hist  = '0;
  logic [LAT-1:0]    eng_v = '0;
  logic [LAT*32-1:0] eng_d = '0;

  function automatic logic [31:0] conv3(input logic [7:0] newest, input logic [HN*8-1:0] h,
                                        input logic [71:0] wt);
    logic signed [31:0] acc;
    logic [7:0] p;
    int d;
    acc = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        d = (2 - r) * W + (2 - c);
        if (d == 0) p = newest;
        else        p = h[8*(d-1) +: 8];
        acc = acc + $signed(wt[8*(r*3+c) +: 8]) * $signed({24'd0, p});
      end
    end
    return acc;
  endfunction

  always @(posedge clk) begin
    eng_v <= {eng_v[LAT-2:0], eng_in_valid};
    eng_d <= {eng_d[(LAT-1)*32-1:0], conv3(eng_in_data, hist, flat_weights)};
    if (eng_in_valid) hist <= {hist[(HN-1)*8-1:0], eng_in_data};
  end
  assign eng_out_valid = eng_v[LAT-1];
  assign eng_out_pixel = eng_d[LAT*32-1 -: 32];

  // Scoreboard monitor: one line per accepted result.
  initial begin
    logic [32:0] exp_v;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got data=%0d last=%0b, required no result", m_data, m_last);
        end else begin
          exp_v = exp_q.pop_front();
          if ({m_last, m_data} !== exp_v) begin
            errors++;
            $display("FAIL result: got data=%0d last=%0b, required data=%0d last=%0b",
                     m_data, m_last, exp_v[31:0], exp_v[32]);
          end else begin
            $display("result data=%0d last=%0b ok", m_data, m_last);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic expect_frame(input logic [31:0] v0, v1, v2, v3);
    exp_q.push_back({1'b0, v0});
    exp_q.push_back({1'b0, v1});
    exp_q.push_back({1'b0, v2});
    exp_q.push_back({1'b1, v3});
  endtask

  task automatic write_cfg(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] d);
    int n = 0;
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL s_ready_timeout: got s_ready=0 for 200 cycles, required 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] px [16], input int n);
    for (int i = 0; i < n; i++) send_pixel(px[i]);
  endtask

  // Returns #1 after the edge that leaves DONE.
  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 500) begin @(negedge clk); n++; end
    check({name, "_done_seen"}, 72'(done), 72'(1));
    @(posedge clk); #1;
    check({name, "_idle_after_done"}, {done, busy}, 72'(0));
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    start = 0; abort = 0; s_valid = 0; s_data = 0; m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin ones[i] = 8'd1; ramp[i] = 8'(i); end
    repeat (3) @(posedge clk); #1;
    check("rst_flags", {s_ready, eng_in_valid, m_valid, m_last, busy, done}, 72'(0));
    check("rst_m_data", 72'(m_data), 72'(0));
    check("rst_weights", flat_weights, 72'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Weights: all ones, out-of-range address ignored.
    for (int i = 0; i < 9; i++) write_cfg(4'(i), 8'd1);
    check("cfg_all_ones", flat_weights, W_ONES);
    write_cfg(4'd9, 8'h55);
    check("cfg_addr9_ignored", flat_weights, W_ONES);

    // Frame 1: all-ones image, free-flowing output; cfg write during RUN ignored.
    expect_frame(9, 9, 9, 9);
    do_start();
    check("f1_busy", 72'(busy), 72'(1));
    write_cfg(4'd4, 8'h7F);
    check("cfg_in_run_ignored", flat_weights, W_ONES);
    send_frame(ones, 16);
    wait_done("f1");
    check("f1_done_count", 72'(done_cnt), 72'(1));

    // Weight write in IDLE lands on bits [39:32]; then restore.
    write_cfg(4'd4, 8'h7F);
    check("cfg_idle_addr4", 72'(flat_weights[39:32]), 72'(8'h7F));
    write_cfg(4'd4, 8'd1);

    // Frame 2: output stalled until input is exhausted, nothing lost.
    m_ready = 1'b0;
    expect_frame(9, 9, 9, 9);
    do_start();
    send_frame(ones, 16);
    repeat (20) @(posedge clk); #1;
    check("bp_held", {s_ready, m_valid, busy, done}, 72'(4'b0110));
    check("bp_no_done", 72'(done_cnt), 72'(1));
    m_ready = 1'b1;
    wait_done("f2");

    // Abort mid-frame with output stalled: no results, no done.
    m_ready = 1'b0;
    do_start();
    send_frame(ones, 12);
    repeat (8) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_flush", {busy, s_ready, m_valid}, 72'(3'b100));
    m_ready = 1'b1;
    begin
      int n = 0;
      while (busy && n < 100) begin @(posedge clk); #1; n++; end
    end
    check("abort_idle", {busy, m_valid, done}, 72'(0));
    check("abort_no_done", 72'(done_cnt), 72'(2));

    // Frame after abort; abort together with start in IDLE must not block start.
    expect_frame(9, 9, 9, 9);
    abort = 1'b1;
    do_start();
    abort = 1'b0;
    check("start_wins", 72'(busy), 72'(1));
    send_frame(ones, 16);
    wait_done("f3");

    // Asynchronous reset mid-frame.
    do_start();
    send_frame(ones, 12);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_flags", {s_ready, eng_in_valid, m_valid, m_last, busy, done}, 72'(0));
    check("midrst_weights", flat_weights, 72'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    check("midrst_ignored", {m_valid, busy, done}, 72'(0));
    for (int i = 0; i < 9; i++) write_cfg(4'(i), 8'd1);

    // Back-to-back frames: second start in the first IDLE cycle after done.
    expect_frame(9, 9, 9, 9);
    do_start();
    send_frame(ones, 16);
    wait_done("b2b_a");
    expect_frame(45, 54, 81, 90);
    do_start();
    send_frame(ramp, 16);
    wait_done("b2b_b");

    repeat (5) @(posedge clk); #1;
    check("queue_drained", 72'(exp_q.size()), 72'(0));
    check("total_done", 72'(done_cnt), 72'(5));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
